// File: rtl/matmul_sequencer.sv
// Sequencer for the 3x3 matmul core. It captures operands A and B from the UART
// receive buffer, triggers the core, and streams the result bytes to the UART transmitter.
module matmul_sequencer #(
  parameter int N_ELEM       = 9,
  parameter int W            = 8,
  parameter int MM_TIMEOUT   = 1024,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_mat_valid,
  input  logic [N_ELEM*W-1:0] i_mat,
  output logic [N_ELEM*W-1:0] o_a,
  output logic [N_ELEM*W-1:0] o_b,
  output logic                o_trigger,
  input  logic                i_mm_ready,
  input  logic [N_ELEM*W-1:0] i_mm_result,
  output logic [W-1:0]        o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_busy,
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_timeout
);

  localparam int CNT_MAX = (MM_TIMEOUT > BUSY_TIMEOUT) ? MM_TIMEOUT : BUSY_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, TRIG, WAIT_MM, TX_LOAD, TX_ACK, TX_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [N_ELEM*W-1:0] result;
  logic                busy_meta, busy_s;

  logic load_a, load_b, trig_set, cnt_clr, cnt_inc, res_load;
  logic tx_load, tx_drop, to_set, idx_inc, overrun_hit;

  // i_tx_busy comes from the baud clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every flop the pre-edge value of its source,
      // which is what makes this a two-stage chain and not a single wire.
      busy_meta <= i_tx_busy;
      busy_s    <= busy_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= WAIT_A;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    trig_set  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    res_load  = 1'b0;
    tx_load   = 1'b0;
    tx_drop   = 1'b0;
    to_set    = 1'b0;
    idx_inc   = 1'b0;
    case (state)
      WAIT_A: if (i_mat_valid) begin
        load_a    = 1'b1;
        state_nxt = WAIT_B;
      end
      WAIT_B: if (i_mat_valid) begin
        load_b    = 1'b1;
        state_nxt = TRIG;
      end
      TRIG: begin
        trig_set  = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = WAIT_MM;
      end
      WAIT_MM: begin
        // The first cycle (cnt == 0) ignores ready so the core can drop a stale result.
        if (cnt != '0 && i_mm_ready) begin
          res_load  = 1'b1;
          state_nxt = TX_LOAD;
        end else if (cnt == CW'(MM_TIMEOUT)) begin
          to_set    = 1'b1;
          state_nxt = WAIT_A;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      TX_LOAD: begin
        tx_load   = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = TX_ACK;
      end
      TX_ACK: begin
        if (busy_s) begin
          tx_drop   = 1'b1;
          state_nxt = TX_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT)) begin
          to_set    = 1'b1;
          tx_drop   = 1'b1;
          state_nxt = WAIT_A;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      TX_DONE: if (!busy_s) begin
        if (idx == IW'(N_ELEM - 1)) begin
          state_nxt = WAIT_A;
        end else begin
          idx_inc   = 1'b1;
          state_nxt = TX_LOAD;
        end
      end
      default: state_nxt = WAIT_A;
    endcase
  end

  // A pulse landing in WAIT_B is consumed as operand B, so only the other states flag it.
  assign overrun_hit = i_mat_valid && (state != WAIT_A) && (state != WAIT_B);
  assign o_busy      = (state != WAIT_A);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a        <= '0;
      o_b        <= '0;
      o_trigger  <= 1'b0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_overrun  <= 1'b0;
      o_timeout  <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      // NOTE: the result register is reset even though it is storage-like, so an aborted
      // transfer can never leak a stale matrix into a later one.
      result     <= '0;
    end else begin
      o_trigger <= trig_set;
      if (load_a) o_a <= i_mat;
      if (load_b) o_b <= i_mat;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (res_load) begin
        result <= i_mm_result;
        idx    <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (tx_load) begin
        o_tx_data  <= result[int'(idx)*W +: W];
        o_tx_start <= 1'b1;
      end else if (tx_drop) begin
        o_tx_start <= 1'b0;
      end
      if (overrun_hit) o_overrun <= 1'b1;
      if (to_set)      o_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: behavioural matmul core and transmitter
// models, a table of directed transfers, and hand-written corner-case sequences.
module tb_matmul_sequencer;
  localparam int N_ELEM  = 9;
  localparam int W       = 8;
  localparam int MW      = N_ELEM * W;
  localparam int MM_TO   = 16;
  localparam int BUSY_TO = 255;

  localparam logic [MW-1:0] M_SEQ   = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [MW-1:0] M_IDENT = 72'h01_00_00_00_01_00_00_00_01;
  localparam logic [MW-1:0] M_REV   = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [MW-1:0] M_TWOS  = 72'h02_02_02_02_02_02_02_02_02;
  localparam logic [MW-1:0] M_SQ    = 72'h96_7E_66_60_51_42_2A_24_1E;
  localparam logic [MW-1:0] M_STALE = 72'hAA_AA_AA_AA_AA_AA_AA_AA_AA;
  localparam logic [MW-1:0] M_FRESH = 72'h11_22_33_44_55_66_77_88_99;
  localparam logic [MW-1:0] M_JUNK  = 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mat_valid;
  logic [MW-1:0] mat;
  logic [MW-1:0] a, b;
  logic          trigger;
  logic          mm_ready;
  logic [MW-1:0] mm_result;
  logic [W-1:0]  tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic          busy, overrun, timeout;

  always #5 clk = ~clk;

  matmul_sequencer #(
    .N_ELEM(N_ELEM), .W(W), .MM_TIMEOUT(MM_TO), .BUSY_TIMEOUT(BUSY_TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mat_valid(mat_valid), .i_mat(mat),
    .o_a(a), .o_b(b), .o_trigger(trigger), .i_mm_ready(mm_ready),
    .i_mm_result(mm_result), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_busy(tx_busy), .o_busy(busy), .o_overrun(overrun), .o_timeout(timeout)
  );

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [MW-1:0] res;
    int            mm_delay;
    int            tx_delay;
    int            tx_len;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Model state shared between the model process and the stimulus.
  int            cyc = 0, trig_count = 0;
  bit            mm_en = 1'b0, mm_armed = 1'b0;
  int            mm_delay = 5, mm_wait = 0, ready_cyc = -1;
  logic [MW-1:0] mm_res = '0;
  int            tx_delay = 1, tx_len = 40;
  int            tx_phase = 0, tx_wait = 0, tx_hold = 0, tx_unstable = 0, first_start_cyc = -1;
  logic [W-1:0]  tx_held = '0;
  logic [W-1:0]  got[$];
  int            holds[$];

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Matmul core and transmitter models, stepped on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        tx_phase = 0;
        tx_busy  = 1'b0;
        mm_armed = 1'b0;
        if (mm_en) mm_ready = 1'b0;
      end else begin
        if (trigger) trig_count++;
        if (mm_en) begin
          if (trigger) begin
            mm_ready = 1'b0;
            mm_wait  = mm_delay;
            mm_armed = 1'b1;
          end else if (mm_armed) begin
            mm_wait--;
            if (mm_wait == 0) begin
              mm_ready  = 1'b1;
              mm_result = mm_res;
              ready_cyc = cyc;
              mm_armed  = 1'b0;
            end
          end
        end
        case (tx_phase)
          0: if (tx_start) begin
            tx_phase = 1;
            tx_wait  = 0;
            tx_held  = tx_data;
            tx_hold  = 1;
            if (first_start_cyc < 0) first_start_cyc = cyc;
          end
          1: begin
            if (!tx_start || tx_data != tx_held) tx_unstable++;
            tx_hold++;
            tx_wait++;
            if (tx_wait == tx_delay) begin
              tx_busy = 1'b1;
              got.push_back(tx_held);
              tx_phase = 2;
              tx_wait  = 0;
            end
          end
          default: begin
            if (tx_start) begin
              tx_hold++;
              if (tx_data != tx_held) tx_unstable++;
            end
            tx_wait++;
            if (tx_wait == tx_len) begin
              tx_busy = 1'b0;
              holds.push_back(tx_hold);
              tx_phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic clear_capture();
    got.delete();
    holds.delete();
    tx_unstable     = 0;
    first_start_cyc = -1;
    ready_cyc       = -1;
  endtask

  task automatic send_mat(input logic [MW-1:0] m);
    tick();
    mat       = m;
    mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
  endtask

  // Sends B and checks the trigger arrives exactly two cycles later; returns in that cycle.
  task automatic send_b(input logic [MW-1:0] m, input string tag);
    tick();
    mat       = m;
    mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
    check({tag, " trigger early"}, MW'(trigger), MW'(0));
    tick();
    check({tag, " trigger at +2"}, MW'(trigger), MW'(1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(got.size() == N_ELEM && !busy) && n < 4000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 4000) begin
      failures++;
      $display("FAIL %s done: bytes=%0d busy=%0b, required 9 bytes and idle", tag, got.size(), busy);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [MW-1:0] exp, input int delay);
    logic [MW-1:0] e = exp;
    check({tag, " byte count"}, MW'(got.size()), MW'(N_ELEM));
    for (int i = 0; i < got.size() && i < N_ELEM; i++)
      check($sformatf("%s byte %0d", tag, i), MW'(got[i]), MW'(e[i*W +: W]));
    for (int i = 0; i < holds.size(); i++) begin
      checks++;
      if (holds[i] < delay + 2 || holds[i] > delay + 3) begin
        failures++;
        $display("FAIL %s hold %0d: actual=%0d required=%0d..%0d", tag, i, holds[i], delay + 2, delay + 3);
      end
    end
    check({tag, " tx stable"}, MW'(tx_unstable), MW'(0));
  endtask

  task automatic run_xfer(input vec_t v, input string tag, input logic exp_ovr, input logic exp_to);
    int t0;
    mm_en    = 1'b1;
    mm_delay = v.mm_delay;
    mm_res   = v.res;
    tx_delay = v.tx_delay;
    tx_len   = v.tx_len;
    clear_capture();
    t0 = trig_count;
    send_mat(v.a);
    send_b(v.b, tag);
    check({tag, " o_a"}, a, v.a);
    check({tag, " o_b"}, b, v.b);
    wait_done(tag);
    check({tag, " trigger pulses"}, MW'(trig_count - t0), MW'(1));
    check_bytes(tag, v.res, v.tx_delay);
    check({tag, " ready->start"}, MW'(first_start_cyc - ready_cyc), MW'(2));
    check({tag, " overrun"}, MW'(overrun), MW'(exp_ovr));
    check({tag, " timeout"}, MW'(timeout), MW'(exp_to));
  endtask

  vec_t vecs[4];

  initial begin
    int t0, n, n_start;
    vecs[0] = '{a: M_SEQ,   b: M_IDENT, res: M_SEQ,   mm_delay: 5, tx_delay: 1, tx_len: 40};
    vecs[1] = '{a: M_SEQ,   b: M_IDENT, res: M_SEQ,   mm_delay: 5, tx_delay: 7, tx_len: 4};
    vecs[2] = '{a: M_IDENT, b: M_REV,   res: M_REV,   mm_delay: 3, tx_delay: 2, tx_len: 3};
    vecs[3] = '{a: M_TWOS,  b: M_SEQ,   res: 72'h24_1E_18_24_1E_18_24_1E_18,
                mm_delay: 1, tx_delay: 1, tx_len: 3};

    rst_n = 1'b0; mat_valid = 1'b0; mat = '0;
    mm_ready = 1'b0; mm_result = '0; tx_busy = 1'b0;
    repeat (3) tick();
    check("reset outs", {a[7:0], b[7:0], tx_data, 3'b0, trigger, tx_start, busy, overrun, timeout},
          '0);
    rst_n = 1'b1;
    tick();
    check("post-reset busy", MW'(busy), MW'(0));
    check("post-reset o_a", a, '0);

    for (int i = 0; i < 4; i++) run_xfer(vecs[i], $sformatf("vec%0d", i), 1'b0, 1'b0);

    // Stale ready: the core holds ready with old data until after the first WAIT_MM cycle.
    mm_en = 1'b0; tx_delay = 1; tx_len = 3;
    clear_capture();
    mm_ready  = 1'b1;
    mm_result = M_STALE;
    send_mat(M_IDENT);
    send_b(M_FRESH, "stale");
    mm_result = M_FRESH;
    tick(); check("stale start +1", MW'(tx_start), MW'(0));
    tick(); check("stale start +2", MW'(tx_start), MW'(0));
    tick(); check("stale start +3", MW'(tx_start), MW'(1));
    check("stale first data", MW'(tx_data), MW'(8'h99));
    mm_ready = 1'b0;
    wait_done("stale");
    check_bytes("stale", M_FRESH, 1);

    // Overrun during WAIT_MM and during TX_DONE.
    mm_en = 1'b1; mm_delay = 5; mm_res = M_SQ; tx_delay = 1; tx_len = 40;
    clear_capture();
    t0 = trig_count;
    send_mat(M_SEQ);
    send_b(M_SEQ, "ovr");
    tick();
    check("ovr before", MW'(overrun), MW'(0));
    mat = M_JUNK; mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
    check("ovr in WAIT_MM", MW'(overrun), MW'(1));
    n = 0;
    while (!(tx_busy && !tx_start && busy && got.size() >= 1) && n < 500) begin
      tick();
      n++;
    end
    check("ovr reach TX_DONE", MW'(n < 500), MW'(1));
    mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
    wait_done("ovr");
    check_bytes("ovr", M_SQ, 1);
    check("ovr o_a", a, M_SEQ);
    check("ovr o_b", b, M_SEQ);
    check("ovr sticky", MW'(overrun), MW'(1));
    check("ovr timeout", MW'(timeout), MW'(0));
    check("ovr pulses", MW'(trig_count - t0), MW'(1));

    // Matmul timeout: ready never rises.
    mm_en = 1'b0; mm_ready = 1'b0;
    clear_capture();
    send_mat(M_SEQ);
    send_b(M_IDENT, "mmto");
    n_start = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (tx_start) n_start++;
      if (k == 16) check("mmto at +16", MW'(timeout), MW'(0));
      if (k == 17) check("mmto at +17", MW'(timeout), MW'(1));
    end
    check("mmto no start", MW'(n_start), MW'(0));
    check("mmto idle", MW'(busy), MW'(0));
    check("mmto no bytes", MW'(got.size()), MW'(0));
    run_xfer(vecs[0], "after mmto", 1'b1, 1'b1);

    // Reset during TX_ACK of byte 4.
    mm_en = 1'b1; mm_delay = 3; mm_res = M_SQ; tx_delay = 2; tx_len = 5;
    clear_capture();
    send_mat(M_SEQ);
    send_b(M_SEQ, "rst");
    n = 0;
    while (!(got.size() == 3 && tx_start) && n < 500) begin
      tick();
      n++;
    end
    check("rst reach byte4", MW'(n < 500), MW'(1));
    rst_n = 1'b0;
    #1;
    check("rst tx_start", MW'(tx_start), MW'(0));
    check("rst outs", {a[7:0], b[7:0], tx_data, 3'b0, trigger, tx_start, busy, overrun, timeout},
          '0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_capture();
    t0 = trig_count;
    send_mat(M_SEQ);
    repeat (10) tick();
    check("rst waits B", MW'(busy), MW'(1));
    check("rst no trigger", MW'(trig_count - t0), MW'(0));
    send_b(M_SEQ, "rst fresh");
    wait_done("rst fresh");
    check_bytes("rst fresh", M_SQ, 2);
    check("rst flags", MW'({overrun, timeout}), MW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
